// File: rtl/param_processor.sv
// param_processor: multi-cycle 8-register processor, one instruction per run request.
// Optional `PROC_FLAGS_EN adds the {Z,N,C,V} flag register and the cmp instruction.
`timescale 1ns/1ps
module param_processor #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              run,
  input  logic [15:0]       DIN,
  output logic              done,
  output logic              busy,
  output logic              illegal,
  output logic [3:0]        flags,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;
  typedef enum logic [2:0] {
    OP_MV = 3'b000, OP_MVT, OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_RSV, OP_ILL
  } opcode_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_regs [8];
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a, r_g;

  opcode_t           w_op;
  logic [2:0]        w_rx, w_ry;
  logic [DATA_W-1:0] w_operand, w_mvt, w_b, w_sum, w_res, w_wdata;
  logic              w_sub, w_is_alu, w_we, w_load_ir, w_load_a, w_load_g;
  logic              w_done_nxt, w_ill_nxt;

  assign w_op      = opcode_t'(r_ir[15:13]);
  assign w_rx      = r_ir[11:9];
  assign w_ry      = r_ir[2:0];
  assign w_operand = r_ir[12] ? {{(DATA_W-9){r_ir[8]}}, r_ir[8:0]} : r_regs[w_ry];
  assign w_mvt     = {r_ir[7:0], {(DATA_W-8){1'b0}}};
  assign w_sub     = (w_op == OP_SUB) || (w_op == OP_CMP);
  assign w_b       = w_sub ? ~w_operand : w_operand;

`ifdef PROC_FLAGS_EN
  logic [DATA_W:0] w_sum_ext;
  logic [3:0]      r_flags, w_flags_nxt;

  assign w_sum_ext = {1'b0, r_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_sub};
  assign w_sum     = w_sum_ext[DATA_W-1:0];
  assign w_is_alu  = w_op inside {OP_ADD, OP_SUB, OP_AND, OP_CMP};
`else
  assign w_sum     = r_a + w_b + {{(DATA_W-1){1'b0}}, w_sub};
  assign w_is_alu  = w_op inside {OP_ADD, OP_SUB, OP_AND};
`endif

  assign w_res    = (w_op == OP_AND) ? (r_a & w_operand) : w_sum;
  assign busy     = (r_state != S_IDLE);
  assign dbg_data = r_regs[dbg_sel];

`ifdef PROC_FLAGS_EN
  // and keeps only Z/N; C is the adder carry-out (1 = no borrow on subtract)
  always_comb begin
    w_flags_nxt = {(w_res == '0), w_res[DATA_W-1], 2'b00};
    if (w_op != OP_AND) begin
      w_flags_nxt[1] = w_sum_ext[DATA_W];
      w_flags_nxt[0] = (r_a[DATA_W-1] == w_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != r_a[DATA_W-1]);
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n)      r_flags <= '0;
    else if (w_load_g) r_flags <= w_flags_nxt;
  end

  assign flags = r_flags;
`else
  assign flags = '0;
`endif

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_ir   = 1'b0;
    w_load_a    = 1'b0;
    w_load_g    = 1'b0;
    w_we        = 1'b0;
    w_wdata     = r_g;
    w_done_nxt  = 1'b0;
    w_ill_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_load_ir   = 1'b1;
          w_state_nxt = S_T1;
        end
      end
      S_T1: begin
        if (w_is_alu) begin
          w_load_a    = 1'b1;
          w_state_nxt = S_T2;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_ill_nxt   = (w_op == OP_ILL);
          w_we        = (w_op == OP_MV) || (w_op == OP_MVT);
          w_wdata     = (w_op == OP_MVT) ? w_mvt : w_operand;
        end
      end
      S_T2: begin
        w_load_g    = 1'b1;
        w_state_nxt = S_T3;
      end
      S_T3: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        w_we        = (w_op != OP_CMP);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      done    <= w_done_nxt;
      illegal <= w_ill_nxt;
      if (w_load_ir) r_ir <= DIN;
      if (w_load_a)  r_a  <= r_regs[w_rx];
      if (w_load_g)  r_g  <= w_res;
      if (w_we)      r_regs[w_rx] <= w_wdata;
    end
  end

endmodule
